// File: rtl/br_pkg.sv
// Shared encodings and constants for the execute-stage branch unit.
package br_pkg;

  localparam int PC_W = 13;

  typedef enum logic [1:0] {
    JUMP_NONE = 2'd0,
    JUMP_JAL  = 2'd1,
    JUMP_JALR = 2'd2
  } jump_code_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } branch_code_t;

  localparam logic [1:0] PHT_RESET = 2'b01;

  // Two-bit saturating counter step.
  function automatic logic [1:0] pht_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    res = cnt;
    if (up && cnt != 2'b11) res = cnt + 2'b01;
    else if (!up && cnt != 2'b00) res = cnt - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/btb_ram.sv
// Direct-mapped branch target buffer: async read, sync write, sync valid clear on NRST.
module btb_ram
  import br_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 7
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [PC_W-1:0]  rd_target,
  output logic             rd_is_jump,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [PC_W-1:0]  wr_target,
  input  logic             wr_is_jump
);

  localparam int N = 2 ** IDX_W;

  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q    [N];
  logic [PC_W-1:0]  target_q [N];
  logic             jump_q   [N];

  always_ff @(posedge CLK) begin
    if (!NRST) valid_q <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  // Payload needs no reset; the valid bit gates every use of it.
  always_ff @(posedge CLK) begin
    if (NRST && wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      jump_q[wr_idx]   <= wr_is_jump;
    end
  end

  assign rd_valid   = valid_q[rd_idx];
  assign rd_tag     = tag_q[rd_idx];
  assign rd_target  = target_q[rd_idx];
  assign rd_is_jump = jump_q[rd_idx];

endmodule

// File: rtl/br_unit.sv
// Execute-stage branch resolution plus PHT/BTB fetch prediction.
// Optional statistics counters are built when BR_STATS_EN is defined.
module br_unit
  import br_pkg::*;
#(
  parameter int PHT_BITS = 6,
  parameter int BTB_BITS = 4
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic [12:0]     pcE,
  input  logic [1:0]      jump_codeE,
  input  logic [2:0]      branch_codeE,
  input  logic [31:0]     op1E,
  input  logic [31:0]     op2E,
  input  logic [31:0]     immE,
  input  logic [12:0]     pcD,
  input  logic            validD,
  input  logic [12:0]     pcF,
  output logic [12:0]     predict_nextF,
  output logic            fail_predictE,
  output logic [12:0]     nextpc,
  output logic [31:0]     br_count,
  output logic [31:0]     miss_count
);

  localparam int TAG_W = PC_W - BTB_BITS - 2;
  localparam int PHT_N = 2 ** PHT_BITS;

  logic            is_jump, is_branch, ctrlE, cond, takenE;
  logic [31:0]     jalr_sum;
  logic [PC_W-1:0] target, pc_plus4;

  // Codes outside the defined sets behave as "none".
  assign is_jump   = (jump_codeE == JUMP_JAL) || (jump_codeE == JUMP_JALR);
  assign is_branch = (branch_codeE >= BR_BEQ) && (branch_codeE <= BR_BGEU);
  assign ctrlE     = is_jump || is_branch;

  always_comb begin
    cond = 1'b0;
    case (branch_codeE)
      BR_BEQ:  cond = (op1E == op2E);
      BR_BNE:  cond = (op1E != op2E);
      BR_BLT:  cond = ($signed(op1E) <  $signed(op2E));
      BR_BGE:  cond = ($signed(op1E) >= $signed(op2E));
      BR_BLTU: cond = (op1E <  op2E);
      BR_BGEU: cond = (op1E >= op2E);
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum = op1E + immE;
  assign pc_plus4 = pcE + 13'd4;
  assign target   = (jump_codeE == JUMP_JALR) ? {jalr_sum[12:1], 1'b0}
                                              : pcE + immE[12:0];
  assign takenE        = is_jump || (is_branch && cond);
  assign nextpc        = takenE ? target : pc_plus4;
  assign fail_predictE = validD && (pcD != nextpc);

  // Pattern history table
  logic [1:0] pht_q [PHT_N];

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= PHT_RESET;
    end else if (is_branch) begin
      pht_q[pcE[PHT_BITS+1:2]] <= pht_step(pht_q[pcE[PHT_BITS+1:2]], takenE);
    end
  end

  logic             btb_valid, btb_is_jump, btb_hit, btb_wr;
  logic [TAG_W-1:0] btb_tag;
  logic [PC_W-1:0]  btb_target;

  assign btb_wr = is_jump || (is_branch && takenE);

  btb_ram #(.IDX_W(BTB_BITS), .TAG_W(TAG_W)) u_btb (
    .CLK        (CLK),
    .NRST       (NRST),
    .rd_idx     (pcF[BTB_BITS+1:2]),
    .rd_valid   (btb_valid),
    .rd_tag     (btb_tag),
    .rd_target  (btb_target),
    .rd_is_jump (btb_is_jump),
    .wr_en      (btb_wr),
    .wr_idx     (pcE[BTB_BITS+1:2]),
    .wr_tag     (pcE[PC_W-1:BTB_BITS+2]),
    .wr_target  (target),
    .wr_is_jump (is_jump)
  );

  assign btb_hit = btb_valid && (btb_tag == pcF[PC_W-1:BTB_BITS+2]);

  // Reads see the pre-write table contents; no bypass from the E-stage write.
  assign predict_nextF = (NRST && btb_hit && (btb_is_jump || pht_q[pcF[PHT_BITS+1:2]][1]))
                         ? btb_target : pcF + 13'd4;

`ifdef BR_STATS_EN
  logic [31:0] br_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (ctrlE && br_cnt_q != 32'hFFFF_FFFF) br_cnt_q <= br_cnt_q + 32'd1;
      if (fail_predictE && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign br_count   = br_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign br_count   = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_br_unit.sv
// Self-checking bench for br_unit: directed vector table, reset corner, then random vs model.
module tb_br_unit;

  logic        CLK = 1'b0;
  logic        NRST;
  logic [12:0] pcE, pcD, pcF;
  logic [1:0]  jump_codeE;
  logic [2:0]  branch_codeE;
  logic [31:0] op1E, op2E, immE;
  logic        validD;
  logic [12:0] predict_nextF, nextpc;
  logic        fail_predictE;
  logic [31:0] br_count, miss_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  br_unit dut (
    .CLK(CLK), .NRST(NRST), .pcE(pcE), .jump_codeE(jump_codeE),
    .branch_codeE(branch_codeE), .op1E(op1E), .op2E(op2E), .immE(immE),
    .pcD(pcD), .validD(validD), .pcF(pcF), .predict_nextF(predict_nextF),
    .fail_predictE(fail_predictE), .nextpc(nextpc), .br_count(br_count),
    .miss_count(miss_count)
  );

  typedef struct {
    logic [1:0]  jump;
    logic [2:0]  br;
    logic [12:0] pce;
    logic [31:0] op1, op2, imm;
    logic [12:0] pcd;
    logic        vd;
    logic [12:0] pcf;
    logic [12:0] e_next;
    logic        e_fail;
    logic [12:0] e_pred;
  } vec_t;

  vec_t vecs[18];

  // Behavioural model state
  int unsigned m_pht[64];
  bit          m_bv[16];
  int unsigned m_btag[16], m_btgt[16];
  bit          m_bj[16];
  int unsigned m_br, m_miss;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] j, input logic [2:0] b, input logic [12:0] pe,
                       input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] im,
                       input logic [12:0] pd, input logic v, input logic [12:0] pf);
    jump_codeE = j; branch_codeE = b; pcE = pe; op1E = o1; op2E = o2; immE = im;
    pcD = pd; validD = v; pcF = pf;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 0;
    m_br = 0; m_miss = 0;
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  initial begin
    int exp_br, exp_miss;

    vecs[0]  = '{2'd0, 3'd0, 13'h0000, 32'd0, 32'd0, 32'd0,   13'h0004, 1'b0, 13'h0040, 13'h0004, 1'b0, 13'h0044};
    vecs[1]  = '{2'd0, 3'd1, 13'h0100, 32'd5, 32'd5, 32'h20,  13'h0104, 1'b1, 13'h0100, 13'h0120, 1'b1, 13'h0104};
    vecs[2]  = '{2'd0, 3'd0, 13'h0104, 32'd0, 32'd0, 32'd0,   13'h0108, 1'b1, 13'h0100, 13'h0108, 1'b0, 13'h0120};
    vecs[3]  = '{2'd0, 3'd1, 13'h0100, 32'd5, 32'd6, 32'h20,  13'h0104, 1'b1, 13'h0100, 13'h0104, 1'b0, 13'h0120};
    vecs[4]  = '{2'd0, 3'd1, 13'h0100, 32'd5, 32'd6, 32'h20,  13'h0104, 1'b1, 13'h0100, 13'h0104, 1'b0, 13'h0104};
    vecs[5]  = '{2'd0, 3'd1, 13'h0100, 32'd5, 32'd6, 32'h20,  13'h0104, 1'b1, 13'h0100, 13'h0104, 1'b0, 13'h0104};
    vecs[6]  = '{2'd0, 3'd0, 13'h0104, 32'd0, 32'd0, 32'd0,   13'h0108, 1'b1, 13'h0100, 13'h0108, 1'b0, 13'h0104};
    vecs[7]  = '{2'd0, 3'd1, 13'h0100, 32'd5, 32'd5, 32'h20,  13'h0120, 1'b1, 13'h0100, 13'h0120, 1'b0, 13'h0104};
    vecs[8]  = '{2'd0, 3'd0, 13'h0104, 32'd0, 32'd0, 32'd0,   13'h0108, 1'b1, 13'h0100, 13'h0108, 1'b0, 13'h0104};
    vecs[9]  = '{2'd2, 3'd0, 13'h0184, 32'h203, 32'd0, 32'd0, 13'h0202, 1'b1, 13'h0184, 13'h0202, 1'b0, 13'h0188};
    vecs[10] = '{2'd0, 3'd0, 13'h0200, 32'd0, 32'd0, 32'd0,   13'h0204, 1'b1, 13'h0184, 13'h0204, 1'b0, 13'h0202};
    vecs[11] = '{2'd1, 3'd0, 13'h1FFC, 32'd0, 32'd0, 32'd4,   13'h0000, 1'b1, 13'h1FFC, 13'h0000, 1'b0, 13'h0000};
    vecs[12] = '{2'd0, 3'd0, 13'h1FFC, 32'd0, 32'd0, 32'd0,   13'h1000, 1'b1, 13'h1FFC, 13'h0000, 1'b1, 13'h0000};
    vecs[13] = '{2'd0, 3'd3, 13'h0400, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 13'h0404, 1'b1, 13'h0040, 13'h03F0, 1'b1, 13'h0044};
    vecs[14] = '{2'd0, 3'd5, 13'h0400, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 13'h0404, 1'b1, 13'h0040, 13'h0404, 1'b0, 13'h0044};
    vecs[15] = '{2'd0, 3'd4, 13'h0800, 32'd1, 32'hFFFFFFFF, 32'd8, 13'h0808, 1'b0, 13'h0040, 13'h0808, 1'b0, 13'h0044};
    vecs[16] = '{2'd0, 3'd6, 13'h0800, 32'd1, 32'hFFFFFFFF, 32'd8, 13'h0808, 1'b1, 13'h0040, 13'h0804, 1'b1, 13'h0044};
    vecs[17] = '{2'd0, 3'd2, 13'h0900, 32'd3, 32'd3, 32'h40,  13'h0904, 1'b1, 13'h0040, 13'h0904, 1'b0, 13'h0044};

    // Clock/reset
    NRST = 1'b0;
    drive(2'd0, 3'd0, 13'h0, 32'd0, 32'd0, 32'd0, 13'h0, 1'b0, 13'h0040);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("reset_pred", predict_nextF, 13'h0044);
    chk("reset_br_count", br_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);
    NRST = 1'b1;

    // Directed vector table
    exp_br = 0; exp_miss = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      drive(vecs[i].jump, vecs[i].br, vecs[i].pce, vecs[i].op1, vecs[i].op2,
            vecs[i].imm, vecs[i].pcd, vecs[i].vd, vecs[i].pcf);
      #1;
      chk($sformatf("vec%0d_nextpc", i), nextpc, vecs[i].e_next);
      chk($sformatf("vec%0d_fail", i), fail_predictE, vecs[i].e_fail);
      chk($sformatf("vec%0d_pred", i), predict_nextF, vecs[i].e_pred);
      if (vecs[i].jump != 0 || vecs[i].br != 0) exp_br++;
      if (vecs[i].e_fail) exp_miss++;
    end
    @(negedge CLK);
    drive(2'd0, 3'd0, 13'h0, 32'd0, 32'd0, 32'd0, 13'h0, 1'b0, 13'h0040);
    #1;
`ifndef BR_STATS_EN
    exp_br = 0; exp_miss = 0;
`endif
    chk("table_br_count", br_count, exp_br);
    chk("table_miss_count", miss_count, exp_miss);

    // Reset coincident with a taken-branch training write: reset must win
    @(negedge CLK);
    NRST = 1'b0;
    drive(2'd0, 3'd1, 13'h0100, 32'd5, 32'd5, 32'h20, 13'h0104, 1'b1, 13'h0100);
    #1;
    chk("inreset_pred", predict_nextF, 13'h0104);
    @(negedge CLK);
    NRST = 1'b1;
    drive(2'd0, 3'd0, 13'h0104, 32'd0, 32'd0, 32'd0, 13'h0108, 1'b0, 13'h0100);
    #1;
    chk("rstwin_pred", predict_nextF, 13'h0104);
    chk("rstwin_br_count", br_count, 32'd0);
    chk("rstwin_miss_count", miss_count, 32'd0);
    model_reset();

    // Randomized stimulus against the model
    for (int it = 0; it < 400; it++) begin
      int unsigned r, pce, pcf, pcd, imm, op1, op2, tgt, nxt, pred, bi, pi, ei, ep;
      int unsigned vals[4];
      bit cond, taken, is_j, is_b, fail, hit;
      logic [1:0] j;
      logic [2:0] b;

      @(negedge CLK);
      r = $urandom_range(0, 9);
      j = 2'd0; b = 3'd0;
      if (r < 2) j = 2'($urandom_range(1, 2));
      else if (r < 8) b = 3'($urandom_range(1, 6));
      pce = ($urandom_range(0, 1) ? 32'h1F00 : 32'h0) + $urandom_range(0, 63) * 4;
      pcf = ($urandom_range(0, 1) ? 32'h1F00 : 32'h0) + $urandom_range(0, 63) * 4;
      vals[0] = 0; vals[1] = 1; vals[2] = 32'hFFFFFFFF; vals[3] = $urandom;
      op1 = vals[$urandom_range(0, 3)];
      op2 = vals[$urandom_range(0, 3)];
      imm = $urandom_range(0, 511) * 2 - 512;

      is_j = (j == 1 || j == 2);
      is_b = (b >= 1 && b <= 6);
      case (b)
        3'd1: cond = (op1 == op2);
        3'd2: cond = (op1 != op2);
        3'd3: cond = ($signed(op1) < $signed(op2));
        3'd4: cond = ($signed(op1) >= $signed(op2));
        3'd5: cond = (op1 < op2);
        3'd6: cond = (op1 >= op2);
        default: cond = 0;
      endcase
      taken = is_j || (is_b && cond);
      tgt = (j == 2) ? ((op1 + imm) & 32'h1FFE) : ((pce + imm) & 32'h1FFF);
      nxt = taken ? tgt : ((pce + 4) & 32'h1FFF);
      pcd = $urandom_range(0, 1) ? nxt : ($urandom_range(0, 2047) * 4);
      fail = r != 9 && (pcd != nxt);

      bi = (pcf >> 2) & 15;
      pi = (pcf >> 2) & 63;
      hit = m_bv[bi] && (m_btag[bi] == (pcf >> 6));
      pred = (hit && (m_bj[bi] || m_pht[pi] >= 2)) ? m_btgt[bi] : ((pcf + 4) & 32'h1FFF);

      drive(j, b, 13'(pce), op1, op2, imm, 13'(pcd), r != 9, 13'(pcf));
      #1;
      chk("rand_nextpc", nextpc, nxt);
      chk("rand_fail", fail_predictE, fail);
      chk("rand_pred", predict_nextF, pred);

      ei = (pce >> 2) & 15;
      ep = (pce >> 2) & 63;
      if (is_b) begin
        if (taken && m_pht[ep] < 3) m_pht[ep]++;
        if (!taken && m_pht[ep] > 0) m_pht[ep]--;
      end
      if (is_j || (is_b && taken)) begin
        m_bv[ei] = 1; m_btag[ei] = pce >> 6; m_btgt[ei] = tgt; m_bj[ei] = is_j;
      end
      if (is_j || is_b) m_br = sat_inc(m_br);
      if (fail) m_miss = sat_inc(m_miss);
    end

    @(negedge CLK);
    drive(2'd0, 3'd0, 13'h0, 32'd0, 32'd0, 32'd0, 13'h0, 1'b0, 13'h0);
    #1;
`ifndef BR_STATS_EN
    m_br = 0; m_miss = 0;
`endif
    chk("rand_br_count", br_count, m_br);
    chk("rand_miss_count", miss_count, m_miss);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
